// File: rtl/wash_setup_fsm_pkg.sv
// wash_setup_fsm_pkg: shared phase type, display codes and width helpers
package wash_setup_fsm_pkg;

    typedef enum logic [1:0] {BAL, MODE, DUR, DONE} phase_t;

    localparam logic [3:0] MINUS = 4'hA;
    localparam logic [3:0] BLANK = 4'hB;

    function automatic int bal_width(input int digits);
        return $clog2(10 ** digits);
    endfunction

    function automatic int mode_width(input int n_modes);
        return (n_modes < 2) ? 1 : $clog2(n_modes);
    endfunction

endpackage

// File: rtl/wash_setup_fsm_bin2bcd.sv
// bin2bcd: combinational double-dabble binary to packed BCD converter
module bin2bcd #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic [W-1:0]   bin,
    output logic [4*D-1:0] bcd
);

    // shift binary in MSB first, adding 3 to any digit >= 5 before each shift
    always_comb begin
        bcd = '0;
        for (int i = W - 1; i >= 0; i--) begin
            for (int j = 0; j < D; j++)
                if (bcd[4*j +: 4] >= 4'd5) bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
            bcd = {bcd[4*D-2:0], bin[i]};
        end
    end

endmodule

// File: rtl/wash_setup_fsm.sv
// wash_setup_fsm: balance entry, mode and duration selection, then start commit
module wash_setup_fsm
    import wash_setup_fsm_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int N_MODES  = 4,
    parameter int TICK_DIV = 66000000,
    parameter int MAX_DUR  = 20,
    parameter int PRICE    = 1,
    localparam int BW      = bal_width(DIGITS),
    localparam int MW      = mode_width(N_MODES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIGITS-1:0]       sw_digit,
    input  logic                    sw_sign,
    input  logic                    sw_tens,
    input  logic                    btn_inc,
    input  logic                    btn_next,
    output logic [4*(DIGITS+1)-1:0] disp_code,
    output logic [3:0]              state_led,
    output logic [BW-1:0]           balance,
    output logic [MW-1:0]           mode,
    output logic [6:0]              duration,
    output logic                    can_start,
    output logic                    start_pulse,
    output logic                    err_led
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    phase_t                  phase, phase_n;
    logic [DIGITS-1:0][3:0]  dig, dig_n;
    logic                    sign, sign_n;
    logic [BW-1:0]           balance_n, entry;
    logic [MW-1:0]           mode_n;
    logic [6:0]              duration_n;
    logic [7:0]              dsum;
    logic [BW+6:0]           cost;
    logic [TW-1:0]           tick, tick_n;
    logic                    wrap, pulse_r, pulse_n, err_n;
    logic                    inc_prev, next_prev, inc_e, next_e;
    logic [DIGITS:0][3:0]    disp;
    logic [4*DIGITS-1:0]     bal_bcd;
    logic [7:0]              dur_bcd;

    assign inc_e       = btn_inc & ~inc_prev;
    assign next_e      = btn_next & ~next_prev;
    assign wrap        = tick == TW'(TICK_DIV - 1);
    assign cost        = {{BW{1'b0}}, duration} * (BW+7)'(PRICE);
    assign can_start   = (duration != 7'd0) && (cost <= {7'd0, balance});
    assign dsum        = {1'b0, duration} + (sw_tens ? 8'd10 : 8'd1);
    assign state_led   = 4'b0001 << phase;
    assign start_pulse = pulse_r & en;
    assign disp_code   = disp;

    bin2bcd #(.W(BW), .D(DIGITS)) u_bal_bcd (.bin(balance), .bcd(bal_bcd));
    bin2bcd #(.W(7), .D(2)) u_dur_bcd (.bin(duration), .bcd(dur_bcd));

    // decimal value of the entry digits, units in digit 0
    always_comb begin
        entry = '0;
        for (int i = DIGITS - 1; i >= 0; i--) entry = entry * BW'(10) + BW'(dig[i]);
    end

    // state register; button history tracks the levels even while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= BAL;
            dig       <= '0;
            sign      <= 1'b0;
            balance   <= '0;
            mode      <= '0;
            duration  <= '0;
            pulse_r   <= 1'b0;
            err_led   <= 1'b0;
            tick      <= '0;
            inc_prev  <= 1'b0;
            next_prev <= 1'b0;
        end else begin
            phase     <= phase_n;
            dig       <= dig_n;
            sign      <= sign_n;
            balance   <= balance_n;
            mode      <= mode_n;
            duration  <= duration_n;
            pulse_r   <= pulse_n;
            err_led   <= err_n;
            tick      <= tick_n;
            inc_prev  <= btn_inc;
            next_prev <= btn_next;
        end
    end

    // next-state logic; confirm wins over increment in the same cycle
    always_comb begin
        phase_n    = phase;
        dig_n      = dig;
        sign_n     = sign;
        balance_n  = balance;
        mode_n     = mode;
        duration_n = duration;
        pulse_n    = 1'b0;
        err_n      = err_led;
        tick_n     = tick;
        if (en) begin
            case (phase)
                BAL: begin
                    tick_n = wrap ? '0 : tick + TW'(1);
                    if (next_e) begin
                        if (sw_digit == '0 && !sw_sign && !sign) begin
                            balance_n = entry;
                            err_n     = 1'b0;
                            phase_n   = MODE;
                        end else begin
                            dig_n  = '0;
                            sign_n = 1'b0;
                            err_n  = 1'b1;
                        end
                    end else if (wrap) begin
                        for (int i = 0; i < DIGITS; i++)
                            if (sw_digit[i]) dig_n[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
                        sign_n = sign ^ sw_sign;
                    end
                end
                MODE: begin
                    if (next_e) begin
                        duration_n = '0;
                        phase_n    = DUR;
                    end else if (inc_e) begin
                        mode_n = (mode == MW'(N_MODES - 1)) ? '0 : mode + MW'(1);
                    end
                end
                DUR: begin
                    if (next_e) begin
                        if (can_start) begin
                            pulse_n   = 1'b1;
                            balance_n = balance - cost[BW-1:0];
                            err_n     = 1'b0;
                            phase_n   = DONE;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (inc_e) begin
                        duration_n = (dsum > 8'(MAX_DUR)) ? 7'd0 : dsum[6:0];
                    end
                end
                DONE: begin
                    if (next_e) begin
                        duration_n = '0;
                        phase_n    = MODE;
                    end
                end
                default: phase_n = BAL;
            endcase
        end
    end

    // per-phase display digit codes for the external scan driver
    always_comb begin
        disp = {(DIGITS+1){BLANK}};
        case (phase)
            BAL: begin
                disp[DIGITS-1:0] = dig;
                disp[DIGITS]     = sign ? MINUS : BLANK;
            end
            MODE: disp[0] = 4'(mode);
            DUR: begin
                disp[1:0]    = dur_bcd;
                disp[DIGITS] = 4'(mode);
            end
            DONE: disp[DIGITS-1:0] = bal_bcd;
            default: disp = {(DIGITS+1){BLANK}};
        endcase
    end

endmodule

// File: tb/tb_wash_setup_fsm.sv
// tb_wash_setup_fsm: directed and randomized checks against a behavioural model
module tb_wash_setup_fsm;

    localparam int DIGITS = 3, N_MODES = 4, TICK_DIV = 4, MAX_DUR = 20, PRICE = 1;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic [2:0]  sw_digit = '0;
    logic        sw_sign = 1'b0, sw_tens = 1'b0, btn_inc = 1'b0, btn_next = 1'b0;
    logic [15:0] disp_code;
    logic [3:0]  state_led;
    logic [9:0]  balance;
    logic [1:0]  mode;
    logic [6:0]  duration;
    logic        can_start, start_pulse, err_led;

    int checks = 0, failures = 0;
    int m_phase, m_sign, m_bal, m_mode, m_dur, m_err, m_pulse, m_tick, p_inc, p_next;
    int m_dig[DIGITS];

    always #5 clk = ~clk;

    wash_setup_fsm #(.DIGITS(DIGITS), .N_MODES(N_MODES), .TICK_DIV(TICK_DIV),
                     .MAX_DUR(MAX_DUR), .PRICE(PRICE)) dut (
        .clk(clk), .rst(rst), .en(en), .sw_digit(sw_digit), .sw_sign(sw_sign),
        .sw_tens(sw_tens), .btn_inc(btn_inc), .btn_next(btn_next),
        .disp_code(disp_code), .state_led(state_led), .balance(balance), .mode(mode),
        .duration(duration), .can_start(can_start), .start_pulse(start_pulse), .err_led(err_led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_sign = 0; m_bal = 0; m_mode = 0; m_dur = 0;
        m_err = 0; m_pulse = 0; m_tick = 0; p_inc = 0; p_next = 0;
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
    endtask

    // one clock of the setup rules applied to the current inputs
    task automatic model_step();
        int ie, ne, wrapped;
        ie = btn_inc && !p_inc;
        ne = btn_next && !p_next;
        p_inc = btn_inc;
        p_next = btn_next;
        m_pulse = 0;
        if (en) begin
            case (m_phase)
                0: begin
                    wrapped = (m_tick == TICK_DIV - 1);
                    m_tick = wrapped ? 0 : m_tick + 1;
                    if (ne) begin
                        if (sw_digit == 0 && !sw_sign && !m_sign) begin
                            m_bal = 0;
                            for (int i = 0; i < DIGITS; i++) m_bal += m_dig[i] * (10 ** i);
                            m_err = 0;
                            m_phase = 1;
                        end else begin
                            for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
                            m_sign = 0;
                            m_err = 1;
                        end
                    end else if (wrapped) begin
                        for (int i = 0; i < DIGITS; i++) if (sw_digit[i]) m_dig[i] = (m_dig[i] + 1) % 10;
                        if (sw_sign) m_sign = !m_sign;
                    end
                end
                1: if (ne) begin m_dur = 0; m_phase = 2; end
                   else if (ie) m_mode = (m_mode + 1) % N_MODES;
                2: if (ne) begin
                       if (m_dur != 0 && m_dur * PRICE <= m_bal) begin
                           m_pulse = 1; m_bal -= m_dur * PRICE; m_err = 0; m_phase = 3;
                       end else m_err = 1;
                   end else if (ie) begin
                       m_dur += sw_tens ? 10 : 1;
                       if (m_dur > MAX_DUR) m_dur = 0;
                   end
                default: if (ne) begin m_dur = 0; m_phase = 1; end
            endcase
        end
    endtask

    function automatic logic [15:0] exp_disp();
        logic [15:0] d;
        d = 16'hBBBB;
        case (m_phase)
            0: begin
                for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'(m_dig[i]);
                d[15:12] = m_sign ? 4'hA : 4'hB;
            end
            1: d[3:0] = 4'(m_mode);
            2: begin d[3:0] = 4'(m_dur % 10); d[7:4] = 4'(m_dur / 10); d[15:12] = 4'(m_mode); end
            default: for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'((m_bal / (10 ** i)) % 10);
        endcase
        return d;
    endfunction

    task automatic compare_all();
        chk("state_led", state_led, 32'(1 << m_phase));
        chk("balance", balance, m_bal);
        chk("mode", mode, m_mode);
        chk("duration", duration, m_dur);
        chk("can_start", can_start, (m_dur != 0 && m_dur * PRICE <= m_bal) ? 1 : 0);
        chk("start_pulse", start_pulse, m_pulse);
        chk("err_led", err_led, m_err);
        chk("disp_code", disp_code, exp_disp());
    endtask

    task automatic step(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
            compare_all();
        end
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; step(1);
        btn_inc = 1'b0; step(1);
    endtask

    task automatic press_next();
        btn_next = 1'b1; step(1);
        btn_next = 1'b0; step(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_state_led", state_led, 4'b0001);
        chk("reset_disp", disp_code, 16'hB000);
        rst = 1'b1;

        // 30 entered via three tens ticks
        sw_digit = 3'b010; step(12);
        sw_digit = 3'b000; btn_next = 1'b1; step(1);
        chk("tp1_balance", balance, 30);
        chk("tp1_state", state_led, 4'b0010);
        chk("tp1_err", err_led, 0);
        btn_next = 1'b0; step(1);

        // negative sign rejects, then empty entry accepts
        do_reset();
        sw_sign = 1'b1; step(4);
        chk("tp2_minus", disp_code, 16'hA000);
        sw_sign = 1'b0; btn_next = 1'b1; step(1);
        chk("tp2_err", err_led, 1);
        chk("tp2_state", state_led, 4'b0001);
        chk("tp2_disp", disp_code, 16'hB000);
        btn_next = 1'b0; step(1);
        press_next();
        chk("tp2_mode", state_led, 4'b0010);
        chk("tp2_err_clr", err_led, 0);

        // balance 15, mode 3, duration 20 is unaffordable
        do_reset();
        sw_digit = 3'b001; step(20);
        sw_digit = 3'b010; step(4);
        sw_digit = 3'b000; press_next();
        chk("tp3_balance", balance, 15);
        repeat (3) press_inc();
        chk("tp3_mode", mode, 3);
        press_next();
        sw_tens = 1'b1; press_inc(); press_inc();
        chk("tp3_dur", duration, 20);
        chk("tp3_can", can_start, 0);
        btn_next = 1'b1; step(1);
        chk("tp3_err", err_led, 1);
        chk("tp3_pulse", start_pulse, 0);
        chk("tp3_state", state_led, 4'b0100);
        btn_next = 1'b0; step(1);

        // duration 20 -> 0 (wrap) -> 10 -> 12, then commit
        press_inc();
        chk("dur_wrap", duration, 0);
        press_inc();
        sw_tens = 1'b0; press_inc(); press_inc();
        chk("tp4_dur", duration, 12);
        chk("tp4_disp", disp_code, 16'h3B12);
        btn_next = 1'b1; step(1);
        chk("tp4_pulse", start_pulse, 1);
        chk("tp4_balance", balance, 3);
        chk("tp4_state", state_led, 4'b1000);
        chk("tp4_disp_done", disp_code, 16'hB003);
        btn_next = 1'b0; step(1);
        chk("tp4_pulse_end", start_pulse, 0);

        // mode wrap, then inc+next together
        press_next();
        chk("tp5_mode_kept", mode, 3);
        press_inc();
        chk("tp5_mode_wrap", mode, 0);
        btn_inc = 1'b1; btn_next = 1'b1; step(1);
        chk("tp5_state", state_led, 4'b0100);
        chk("tp5_mode", mode, 0);
        btn_inc = 1'b0; btn_next = 1'b0; step(1);

        // disabled confirm leaves no stale edge
        en = 1'b0; btn_next = 1'b1; step(3);
        chk("tp6_hold", state_led, 4'b0100);
        en = 1'b1; step(2);
        chk("tp6_no_edge", state_led, 4'b0100);
        btn_next = 1'b0; step(1);
        sw_tens = 1'b1; press_inc();

        // asynchronous reset mid-DUR
        rst = 1'b0;
        #2;
        model_reset();
        chk("tp6_rst_state", state_led, 4'b0001);
        chk("tp6_rst_dur", duration, 0);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sw_tens = 1'b0;
        step(1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            en       = ($urandom_range(0, 15) != 0);
            btn_inc  = ($urandom_range(0, 2) == 0);
            btn_next = ($urandom_range(0, 5) == 0);
            sw_digit = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            sw_sign  = ($urandom_range(0, 20) == 0);
            sw_tens  = 1'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
